// File: rtl/sl_word_transmitter_if.sv
// Word handoff from the APB register block (valid/ready) plus the two SL line outputs.
interface sl_word_transmitter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 6;

    logic [DATA_W-1:0] tx_data;
    logic [LEN_W-1:0]  cfg_word_len;
    logic              cfg_parity_odd;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_busy;
    logic              tx_done;
    logic              sl0;
    logic              sl1;

    modport master (
        output tx_data, cfg_word_len, cfg_parity_odd, tx_valid,
        input  tx_ready, tx_busy, tx_done, sl0, sl1
    );

    modport slave (
        input  tx_data, cfg_word_len, cfg_parity_odd, tx_valid,
        output tx_ready, tx_busy, tx_done, sl0, sl1
    );
endinterface

// File: rtl/sl_word_transmitter.sv
// Serializes one word LSB-first onto the two-wire SL line (low pulse on sl0 = '0', sl1 = '1', both = stop).
// Optional parity symbol before stop is built when SL_TX_PARITY_EN is defined.
module sl_word_transmitter #(
    parameter int unsigned BIT_PERIOD   = 16,
    parameter int unsigned MIN_WORD_LEN = 8,
    parameter int unsigned MAX_WORD_LEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sl_word_transmitter_if.slave bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEN_W   = 6;
    localparam int unsigned IDX_W   = $clog2(DATA_W);
    localparam int unsigned PHASE_W = $clog2(BIT_PERIOD);
    localparam int unsigned HALF    = BIT_PERIOD / 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef SL_TX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [LEN_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 sl0_q, sl0_d;
    logic                 sl1_q, sl1_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
`ifdef SL_TX_PARITY_EN
    logic                 parity_q, parity_d;
`else
    logic                 unused_parity_odd;
`endif

    logic                 accept_c;
    logic                 wrap_c;
    logic                 low_phase_c;
    logic                 last_bit_c;
    logic [LEN_W-1:0]     len_c;
    logic [DATA_W-1:0]    mask_c;
    logic [DATA_W-1:0]    word_c;
    logic                 pull0_c;
    logic                 pull1_c;

    // Clamp the requested length and keep only the bits that will be sent.
    always_comb begin
        len_c = bus.cfg_word_len;
        if (bus.cfg_word_len < LEN_W'(MIN_WORD_LEN)) begin
            len_c = LEN_W'(MIN_WORD_LEN);
        end else if (bus.cfg_word_len > LEN_W'(MAX_WORD_LEN)) begin
            len_c = LEN_W'(MAX_WORD_LEN);
        end
        mask_c = DATA_W'((64'd1 << len_c) - 64'd1);
        word_c = bus.tx_data & mask_c;
    end

`ifndef SL_TX_PARITY_EN
    assign unused_parity_odd = bus.cfg_parity_odd;
`endif

    assign accept_c    = bus.tx_valid && tx_ready_q && (state_q == ST_IDLE);
    assign wrap_c      = (phase_q == PHASE_W'(BIT_PERIOD - 1));
    assign low_phase_c = (phase_q < PHASE_W'(HALF));
    assign last_bit_c  = (bit_cnt_q == (len_q - LEN_W'(1)));

    // Next-state and registered-output decode; line levels lag the symbol state by one cycle.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        data_d     = data_q;
`ifdef SL_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        pull0_c    = 1'b0;
        pull1_c    = 1'b0;

        if (state_q != ST_IDLE) begin
            phase_d = wrap_c ? '0 : (phase_q + PHASE_W'(1));
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    data_d    = word_c;
                    len_d     = len_c;
`ifdef SL_TX_PARITY_EN
                    parity_d  = (^word_c) ^ bus.cfg_parity_odd;
`endif
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_q[bit_cnt_q[IDX_W-1:0]]) begin
                    pull1_c = low_phase_c;
                end else begin
                    pull0_c = low_phase_c;
                end
                if (wrap_c) begin
                    if (last_bit_c) begin
                        bit_cnt_d = '0;
`ifdef SL_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    end
                end
            end
`ifdef SL_TX_PARITY_EN
            ST_PARITY: begin
                if (parity_q) begin
                    pull1_c = low_phase_c;
                end else begin
                    pull0_c = low_phase_c;
                end
                if (wrap_c) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                pull0_c = low_phase_c;
                pull1_c = low_phase_c;
                if (wrap_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        sl0_d      = ~pull0_c;
        sl1_d      = ~pull1_c;
        tx_ready_d = (state_q == ST_IDLE) && !accept_c;
        tx_busy_d  = accept_c || (state_q != ST_IDLE);
        // Done fires on the first cycle back in IDLE while busy is still showing.
        tx_done_d  = (state_q == ST_IDLE) && tx_busy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            len_q      <= '0;
            data_q     <= '0;
`ifdef SL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            sl0_q      <= 1'b1;
            sl1_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
`ifdef SL_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            sl0_q      <= sl0_d;
            sl1_q      <= sl1_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign bus.sl0      = sl0_q;
    assign bus.sl1      = sl1_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.tx_busy  = tx_busy_q;
    assign bus.tx_done  = tx_done_q;
endmodule

// File: tb/tb_sl_word_transmitter.sv
// Bench for sl_word_transmitter: frame-level model checked every cycle plus directed literal checks.
module tb_sl_word_transmitter;
    localparam int BP = 8;
    localparam int HP = BP / 2;
`ifdef SL_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int LAT8  = 81;
    localparam int LAT32 = 273;
`else
    localparam bit PAR   = 1'b0;
    localparam int LAT8  = 73;
    localparam int LAT32 = 265;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    sl_word_transmitter_if bus();

    sl_word_transmitter #(.BIT_PERIOD(BP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: symbol list (0 = sl0 pulse, 1 = sl1 pulse, 2 = stop) and cycle offset since accept.
    int m_sym[$];
    bit m_active = 1'b0;
    int m_k = 0;
    int pulses[$];
    int done_cnt = 0;
    logic [1:0] prev_sl = 2'b11;

    task automatic build_frame(input logic [31:0] d, input int l, input bit odd);
        int n;
        int ones;
        n = (l < 8) ? 8 : ((l > 32) ? 32 : l);
        ones = 0;
        m_sym.delete();
        for (int i = 0; i < n; i++) begin
            m_sym.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        if (PAR) m_sym.push_back((ones % 2) ^ int'(odd));
        m_sym.push_back(2);
    endtask

    always @(posedge clk) begin
        int   last_k;
        int   s;
        int   p;
        logic e0, e1, erdy, ebsy, edn;
        last_k = m_sym.size() * BP + 1;
        if (reset) begin
            m_active = 1'b0;
        end else if ((!m_active || m_k == last_k) && bus.tx_valid === 1'b1) begin
            build_frame(bus.tx_data, int'(bus.cfg_word_len), bus.cfg_parity_odd);
            m_active = 1'b1;
            m_k = 0;
        end else if (m_active) begin
            if (m_k == last_k) m_active = 1'b0;
            else m_k++;
        end
        #1;
        last_k = m_sym.size() * BP + 1;
        e0 = 1'b1; e1 = 1'b1; erdy = 1'b1; ebsy = 1'b0; edn = 1'b0;
        if (m_active) begin
            if (m_k == last_k) begin
                edn = 1'b1;
            end else begin
                erdy = 1'b0;
                ebsy = 1'b1;
                if (m_k >= 1) begin
                    s = (m_k - 1) / BP;
                    p = (m_k - 1) % BP;
                    if (p < HP) begin
                        case (m_sym[s])
                            0: e0 = 1'b0;
                            1: e1 = 1'b0;
                            default: begin e0 = 1'b0; e1 = 1'b0; end
                        endcase
                    end
                end
            end
        end
        chk("m_sl0", bus.sl0, e0);
        chk("m_sl1", bus.sl1, e1);
        chk("m_ready", bus.tx_ready, erdy);
        chk("m_busy", bus.tx_busy, ebsy);
        chk("m_done", bus.tx_done, edn);
        // Pulse log for the directed checks.
        if (prev_sl == 2'b11 && {bus.sl0, bus.sl1} != 2'b11) begin
            if ({bus.sl0, bus.sl1} == 2'b01) pulses.push_back(0);
            else if ({bus.sl0, bus.sl1} == 2'b10) pulses.push_back(1);
            else pulses.push_back(2);
        end
        prev_sl = {bus.sl0, bus.sl1};
        if (bus.tx_done === 1'b1) done_cnt++;
    end

    task automatic send(input logic [31:0] d, input logic [5:0] l, input logic odd);
        int g = 0;
        @(negedge clk);
        bus.tx_data        = d;
        bus.cfg_word_len   = l;
        bus.cfg_parity_odd = odd;
        bus.tx_valid       = 1'b1;
        while (bus.tx_ready !== 1'b1 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        pulses.delete();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (bus.tx_done !== 1'b1 && lat < 400);
        if (bus.tx_done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_pulses(input string name, input int exp[$]);
        chk({name, "_count"}, 64'(pulses.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < pulses.size(); i++) begin
            chk(name, 64'(pulses[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        int lat;
        int done_before;
        int ex[$];
        reset              = 1'b1;
        bus.tx_valid       = 1'b0;
        bus.tx_data        = '0;
        bus.cfg_word_len   = 6'd8;
        bus.cfg_parity_odd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sl0", bus.sl0, 1'b1);
        chk("rst_sl1", bus.sl1, 1'b1);
        chk("rst_ready", bus.tx_ready, 1'b1);
        chk("rst_busy", bus.tx_busy, 1'b0);
        chk("rst_done", bus.tx_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 0xA5, 8 bits, even parity
        send(32'hA5, 6'd8, 1'b0);
        wait_done(lat);
        chk("a5_latency", 64'(lat), 64'(LAT8));
`ifdef SL_TX_PARITY_EN
        ex = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 2};
`else
        ex = '{1, 0, 1, 0, 0, 1, 0, 1, 2};
`endif
        chk_pulses("a5_pulses", ex);

        // All ones, 32 bits, odd parity
        send(32'hFFFF_FFFF, 6'd32, 1'b1);
        wait_done(lat);
        chk("ones32_latency", 64'(lat), 64'(LAT32));
        ex.delete();
        for (int i = 0; i < 32; i++) ex.push_back(1);
`ifdef SL_TX_PARITY_EN
        ex.push_back(1);
`endif
        ex.push_back(2);
        chk_pulses("ones32_pulses", ex);

        // Short length clamps up to 8; bit 8 not sent
        send(32'h1FF, 6'd3, 1'b0);
        wait_done(lat);
        chk("short_latency", 64'(lat), 64'(LAT8));
        ex.delete();
        for (int i = 0; i < 8; i++) ex.push_back(1);
`ifdef SL_TX_PARITY_EN
        ex.push_back(0);
`endif
        ex.push_back(2);
        chk_pulses("short_pulses", ex);

        // Long length clamps down to 32
        send(32'h8000_0001, 6'd63, 1'b0);
        wait_done(lat);
        chk("long_latency", 64'(lat), 64'(LAT32));
        ex.delete();
        ex.push_back(1);
        for (int i = 0; i < 30; i++) ex.push_back(0);
        ex.push_back(1);
`ifdef SL_TX_PARITY_EN
        ex.push_back(0);
`endif
        ex.push_back(2);
        chk_pulses("long_pulses", ex);

        // tx_valid held through a frame: new word only taken on the done cycle
        send(32'h0F, 6'd8, 1'b0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 32'hF0;
        wait_done(lat);
        chk("hold_a_latency", 64'(lat), 64'(LAT8));
        chk("hold_a_ready", bus.tx_ready, 1'b1);
`ifdef SL_TX_PARITY_EN
        ex = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 2};
`else
        ex = '{1, 1, 1, 1, 0, 0, 0, 0, 2};
`endif
        chk_pulses("hold_a_pulses", ex);
        pulses.delete();
        @(posedge clk);
        #1;
        chk("b2b_busy", bus.tx_busy, 1'b1);
        chk("b2b_ready", bus.tx_ready, 1'b0);
        chk("b2b_done", bus.tx_done, 1'b0);
        bus.tx_valid = 1'b0;
        wait_done(lat);
        chk("hold_b_latency", 64'(lat), 64'(LAT8));
`ifdef SL_TX_PARITY_EN
        ex = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 2};
`else
        ex = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
`endif
        chk_pulses("hold_b_pulses", ex);

        // Reset during the 5th symbol (bit 4 of 0xA5 is 0 -> sl0 low)
        send(32'hA5, 6'd8, 1'b0);
        done_before = done_cnt;
        repeat (34) @(posedge clk);
        #2;
        chk("pre_reset_sl0", bus.sl0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_sl0", bus.sl0, 1'b1);
        chk("midrst_sl1", bus.sl1, 1'b1);
        chk("midrst_ready", bus.tx_ready, 1'b1);
        chk("midrst_busy", bus.tx_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(done_cnt), 64'(done_before));
        send(32'h3C, 6'd8, 1'b0);
        wait_done(lat);
        chk("post_rst_latency", 64'(lat), 64'(LAT8));
`ifdef SL_TX_PARITY_EN
        ex = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 2};
`else
        ex = '{0, 0, 1, 1, 1, 1, 0, 0, 2};
`endif
        chk_pulses("post_rst_pulses", ex);

        repeat (5) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
